// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and FSM state type for the multi-cycle control unit.
package rv32i_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_TYPE_R  = 7'b0110011;
  localparam logic [6:0] OP_TYPE_L  = 7'b0000011;
  localparam logic [6:0] OP_TYPE_I  = 7'b0010011;
  localparam logic [6:0] OP_TYPE_S  = 7'b0100011;
  localparam logic [6:0] OP_TYPE_B  = 7'b1100011;
  localparam logic [6:0] OP_TYPE_LU = 7'b0110111;
  localparam logic [6:0] OP_TYPE_AU = 7'b0010111;
  localparam logic [6:0] OP_TYPE_J  = 7'b1101111;
  localparam logic [6:0] OP_TYPE_JL = 7'b1100111;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  // Branch compare codes (aluControl[2:0] in B_EXE)
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  // Register-file write-data source select
  localparam logic [2:0] RFWD_ALU   = 3'd0;
  localparam logic [2:0] RFWD_LOAD  = 3'd1;
  localparam logic [2:0] RFWD_IMM   = 3'd2;
  localparam logic [2:0] RFWD_PCIMM = 3'd3;
  localparam logic [2:0] RFWD_PC4   = 3'd4;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    R_EXE  = 4'd2,
    I_EXE  = 4'd3,
    B_EXE  = 4'd4,
    LU_EXE = 4'd5,
    AU_EXE = 4'd6,
    J_EXE  = 4'd7,
    JL_EXE = 4'd8,
    S_EXE  = 4'd9,
    S_MEM  = 4'd10,
    L_EXE  = 4'd11,
    L_MEM  = 4'd12,
    L_WB   = 4'd13
  } state_e;

  // Execute state reached from DECODE; unknown opcodes fall back to FETCH.
  function automatic state_e decode_exe_state(input logic [6:0] opcode);
    state_e st;
    case (opcode)
      OP_TYPE_R:  st = R_EXE;
      OP_TYPE_L:  st = L_EXE;
      OP_TYPE_I:  st = I_EXE;
      OP_TYPE_S:  st = S_EXE;
      OP_TYPE_B:  st = B_EXE;
      OP_TYPE_LU: st = LU_EXE;
      OP_TYPE_AU: st = AU_EXE;
      OP_TYPE_J:  st = J_EXE;
      OP_TYPE_JL: st = JL_EXE;
      default:    st = FETCH;
    endcase
    return st;
  endfunction

  function automatic logic is_legal_opcode(input logic [6:0] opcode);
    logic legal;
    case (opcode)
      OP_TYPE_R, OP_TYPE_L, OP_TYPE_I, OP_TYPE_S, OP_TYPE_B,
      OP_TYPE_LU, OP_TYPE_AU, OP_TYPE_J, OP_TYPE_JL: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational ALU-op decoder shared by the single- and multi-cycle control paths.
module alu_decoder
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       instr30_i,
  output logic [3:0] alu_control_o
);

  // Map instruction class and funct fields onto an ALU operation
  always_comb begin
    alu_control_o = ALU_ADD;
    case (opcode_i)
      OP_TYPE_R: alu_control_o = {instr30_i, funct3_i};
      // Only SRAI uses bit 30 among immediates; ADDI with imm[10]=1 must stay ADD.
      OP_TYPE_I: alu_control_o = {instr30_i & (funct3_i == 3'b101), funct3_i};
      OP_TYPE_B: alu_control_o = {1'b0, funct3_i};
      default:   alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM driving DataPath controls, PC enable and data bus.
module multicycle_control_unit
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  input  logic        busReady,
  output logic        regFileWe,
  output logic [3:0]  aluControl,
  output logic        aluSrcMuxSel,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        pcEn,
  output logic        busWe,
  output logic        busRe,
  output logic        illegalInstr,
  output logic [3:0]  state
);

  state_e     state_q;
  state_e     state_d;
  logic [6:0] opcode_s;
  logic       reg_we_s;
  logic       pc_en_s;
  logic       bus_we_s;
  logic       bus_re_s;
  logic       illegal_s;
  logic       unused_instr_bits_s;

  assign opcode_s            = instrCode[6:0];
  assign unused_instr_bits_s = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  alu_decoder u_alu_decoder (
    .opcode_i      (opcode_s),
    .funct3_i      (instrCode[14:12]),
    .instr30_i     (instrCode[30]),
    .alu_control_o (aluControl)
  );

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: MEM states wait on busReady, every other path returns to FETCH
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE:  state_d = decode_exe_state(opcode_s);
      S_EXE:   state_d = S_MEM;
      S_MEM:   state_d = busReady ? FETCH : S_MEM;
      L_EXE:   state_d = L_MEM;
      L_MEM:   state_d = busReady ? L_WB : L_MEM;
      default: state_d = FETCH;
    endcase
  end

  // Per-state control outputs; the PC advances exactly once per instruction
  always_comb begin
    reg_we_s      = 1'b0;
    aluSrcMuxSel  = 1'b0;
    RFWDSrcMuxSel = RFWD_ALU;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    pc_en_s       = 1'b0;
    bus_we_s      = 1'b0;
    bus_re_s      = 1'b0;
    illegal_s     = 1'b0;
    case (state_q)
      DECODE: begin
        // Unknown opcode: skip the instruction without touching RF or bus
        illegal_s = ~is_legal_opcode(opcode_s);
        pc_en_s   = ~is_legal_opcode(opcode_s);
      end
      R_EXE: begin
        reg_we_s = 1'b1;
        pc_en_s  = 1'b1;
      end
      I_EXE: begin
        reg_we_s     = 1'b1;
        aluSrcMuxSel = 1'b1;
        pc_en_s      = 1'b1;
      end
      B_EXE: begin
        branch  = 1'b1;
        pc_en_s = 1'b1;
      end
      LU_EXE: begin
        reg_we_s      = 1'b1;
        RFWDSrcMuxSel = RFWD_IMM;
        pc_en_s       = 1'b1;
      end
      AU_EXE: begin
        reg_we_s      = 1'b1;
        RFWDSrcMuxSel = RFWD_PCIMM;
        pc_en_s       = 1'b1;
      end
      J_EXE: begin
        reg_we_s      = 1'b1;
        jal           = 1'b1;
        RFWDSrcMuxSel = RFWD_PC4;
        pc_en_s       = 1'b1;
      end
      JL_EXE: begin
        reg_we_s      = 1'b1;
        jal           = 1'b1;
        jalr          = 1'b1;
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = RFWD_PC4;
        pc_en_s       = 1'b1;
      end
      S_EXE: begin
        aluSrcMuxSel = 1'b1;
      end
      S_MEM: begin
        aluSrcMuxSel = 1'b1;
        bus_we_s     = 1'b1;
        pc_en_s      = busReady;
      end
      L_EXE: begin
        aluSrcMuxSel = 1'b1;
      end
      L_MEM: begin
        aluSrcMuxSel = 1'b1;
        bus_re_s     = 1'b1;
      end
      L_WB: begin
        aluSrcMuxSel  = 1'b1;
        reg_we_s      = 1'b1;
        RFWDSrcMuxSel = RFWD_LOAD;
        pc_en_s       = 1'b1;
      end
      default: begin
        reg_we_s = 1'b0;
      end
    endcase
  end

  // Reset kills every strobe immediately so a pending bus access is dropped
  assign regFileWe    = reg_we_s  & ~reset;
  assign pcEn         = pc_en_s   & ~reset;
  assign busWe        = bus_we_s  & ~reset;
  assign busRe        = bus_re_s  & ~reset;
  assign illegalInstr = illegal_s & ~reset;
  assign state        = state_q;

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle RV32I control unit. A Moore FSM walks each instruction through FETCH, DECODE, EXECUTE and, where needed, MEM and WB states. It drives the existing DataPath control inputs, the PC enable and a ready-handshaked data-bus interface. It sits beside DataPath in the multi-cycle CPU top and replaces the single-cycle combinational decoder. A fetched instruction must be held stable by instruction memory until `pcEn` pulses.

## Interface
Parameters: none. Opcode and ALU encodings are fixed constants from the shared package.

Ports:
- clk  in  1  system clock; rising-edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- instrCode  in  32  current instruction from instruction memory
- busReady  in  1  data bus completes the current access this cycle
- regFileWe  out  1  register-file write strobe
- aluControl  out  4  ALU op; [2:0] also selects the branch compare
- aluSrcMuxSel  out  1  0 = RFData2, 1 = immExt
- RFWDSrcMuxSel  out  3  0 = ALU, 1 = load data, 2 = imm, 3 = PC+imm, 4 = PC+4
- branch  out  1  branch instruction in EXE
- jal  out  1  force PC+imm select (JAL and JALR)
- jalr  out  1  PC adder base = RFData1
- pcEn  out  1  PC register load, one cycle per retired instruction
- busWe  out  1  store request
- busRe  out  1  load request
- illegalInstr  out  1  one-cycle pulse on an unknown opcode
- state  out  4  current FSM state, for debug

## Operation
- State encodings:
  - FETCH = 0, DECODE = 1
  - R_EXE = 2, I_EXE = 3, B_EXE = 4, LU_EXE = 5, AU_EXE = 6, J_EXE = 7, JL_EXE = 8
  - S_EXE = 9, S_MEM = 10, L_EXE = 11, L_MEM = 12, L_WB = 13
- Transitions:
  - FETCH → DECODE, unconditionally.
  - DECODE → the `*_EXE` state selected by opcode[6:0]. Opcodes: R 0110011, L 0000011, I 0010011, S 0100011, B 1100011, LU 0110111, AU 0010111, J 1101111, JL 1100111.
  - DECODE with any other opcode → FETCH, with `pcEn` = 1 and `illegalInstr` = 1 for that cycle (the instruction is skipped).
  - R/I/B/LU/AU/J/JL_EXE → FETCH, with `pcEn` = 1.
  - S_EXE → S_MEM. S_MEM holds while `busReady` = 0; on `busReady` = 1 it goes to FETCH with `pcEn` = 1.
  - L_EXE → L_MEM. L_MEM holds while `busReady` = 0; on `busReady` = 1 it goes to L_WB.
  - L_WB → FETCH, with `pcEn` = 1.
- `aluControl` encodings: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- `aluControl` by instruction class:
  - R: {instr[30], funct3}.
  - I: {instr[30] & (funct3 == 101), funct3}, so ADDI never decodes as SUB.
  - B: {0, funct3}. Branch codes BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
  - All other classes: ADD.
- Per-state outputs. Any output not listed is 0; `aluControl` is always decoded from instrCode.
  - R_EXE: regFileWe, RFWD = 0.
  - I_EXE: regFileWe, aluSrc = 1, RFWD = 0.
  - B_EXE: branch.
  - LU_EXE: regFileWe, RFWD = 2.
  - AU_EXE: regFileWe, RFWD = 3.
  - J_EXE: regFileWe, jal, RFWD = 4.
  - JL_EXE: regFileWe, jal, jalr, aluSrc = 1, RFWD = 4.
  - S_EXE and S_MEM: aluSrc = 1. S_MEM additionally drives busWe.
  - L_EXE, L_MEM and L_WB: aluSrc = 1. L_MEM additionally drives busRe. L_WB additionally drives regFileWe with RFWD = 1.
- `pcEn` is the only PC update. The PC does not change in any other cycle.
- Illegal opcodes never assert regFileWe, busWe or busRe.

## Timing
- Reset:
  - `reset` = 1 at a rising edge → state = FETCH after that edge.
  - While `reset` is high, `regFileWe`, `pcEn`, `busWe`, `busRe` and `illegalInstr` are forced to 0 combinationally.
  - Reset mid-access drops a pending store or load; no write completes.
- Reset output values: all strobes 0, `aluSrcMuxSel` = 0, `RFWDSrcMuxSel` = 0, `state` = 0.
- Latency:
  - R/I/B/LU/AU/J/JL: 3 cycles.
  - Store: 4 + N cycles. Load: 5 + N cycles. N = number of `busReady`-low cycles in the MEM state.
  - Illegal opcode: 2 cycles.
- Bus handshake:
  - `busWe`/`busRe` are asserted from MEM-state entry and held until `busReady` is sampled high.
  - `busReady` is ignored in every other state.
  - `busReady` held permanently high gives N = 0.
- `busWe`/`busRe` assert in MEM states only. `regFileWe` is never asserted in the same cycle as either bus strobe.

## Structure
- Package `rv32i_pkg`:
  - opcode constants `OP_TYPE_*`
  - ALU codes and branch codes
  - RFWD select constants
  - `state_e` enum (4-bit)
- One combinational sub-module, `alu_decoder` (opcode, funct3, instr[30] → aluControl). Keep it separate so the single-cycle path can reuse it.
- Implementation: one `always_ff` for the state register and one `always_comb` each for next-state and outputs.

## Test plan
- Reset, then `add x3,x1,x2` (0x002081B3), `busReady` = 1 → states 0, 1, 2; in cycle 3 `regFileWe` = 1, `aluControl` = 0000, `pcEn` = 1.
- `sub` 0x402081B3 → `aluControl` = 1000. `addi x1,x1,-1` (0xFFF08093) → `aluControl` = 0000 with `aluSrcMuxSel` = 1.
- `lw x5,8(x1)` (0x0080A283) with `busReady` low for 2 cycles → `busRe` high for 3 cycles, then L_WB with `regFileWe` = 1 and RFWD = 1. Total 7 cycles.
- `sw x2,4(x1)` (0x0020A223), `busReady` = 1 → `busWe` for exactly 1 cycle; `regFileWe` never asserted; 4 cycles.
- `beq` 0x00208463 → B_EXE with `branch` = 1 and `aluControl` = 0000. `jal x1,8` (0x008000EF) → `jal` = 1 and RFWD = 4.
- 0xFFFFFFFF → `illegalInstr` and `pcEn` pulse in DECODE, back to FETCH. Reset asserted in L_MEM → `busRe` drops in the same cycle, and state = 0 after the edge.
